bram_asym_fifo_ctrl: RTL and testbench

Stream-side controller for the narrow-write / wide-read single-clock BRAM macros (16→32, 8→16, 8→32 lane ratios).
- Accepts a narrow valid/ready input stream and writes it lane by lane into the RAM write port.
- Tracks when whole wide words are complete, reads them through the 1-cycle-latency registered read port, and presents them on a wide valid/ready output stream.
- Instantiated beside the RAM: drives wce/wa/wd and rce/ra, and consumes rq.

---
 rtl/bram_asym_fifo_ctrl.sv | 94 +++++++++
 tb/tb_bram_asym_fifo_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_asym_fifo_ctrl.sv
// rtl/bram_asym_fifo_ctrl.sv - narrow-write / wide-read stream controller for asymmetric BRAM macros
module bram_asym_fifo_ctrl #(
    parameter int WR_WIDTH  = 16,
    parameter int RATIO     = 2,
    parameter int RD_ADDR_W = 10,
    localparam int LR        = (RATIO == 4) ? 2 : 1,
    localparam int RD_WIDTH  = WR_WIDTH * RATIO,
    localparam int WR_ADDR_W = RD_ADDR_W + LR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WR_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RD_WIDTH-1:0]  out_data,
    output logic                 mem_wce,
    output logic [WR_ADDR_W-1:0] mem_wa,
    output logic [WR_WIDTH-1:0]  mem_wd,
    output logic                 mem_rce,
    output logic [RD_ADDR_W-1:0] mem_ra,
    input  logic [RD_WIDTH-1:0]  mem_rq,
    output logic [WR_ADDR_W:0]   lane_level
);

    localparam logic [WR_ADDR_W:0] FULL_LVL = {1'b1, {WR_ADDR_W{1'b0}}};

    logic [WR_ADDR_W:0]  wptr;
    logic [RD_ADDR_W:0]  rptr;
    logic                pending;
    logic [1:0]          buf_count;
    logic [RD_WIDTH-1:0] obuf0;
    logic [RD_WIDTH-1:0] obuf1;
    logic [RD_ADDR_W:0]  words_avail;
    logic [2:0]          credit_used;
    logic                full;
    logic                accept;
    logic                pop;
    logic                issue;

    assign lane_level  = wptr - {rptr, {LR{1'b0}}};
    assign full        = (lane_level == FULL_LVL);
    assign in_ready    = !rst && !full;
    assign accept      = in_valid && in_ready;

    assign mem_wce     = accept;
    assign mem_wa      = wptr[WR_ADDR_W-1:0];
    assign mem_wd      = in_data;

    // Only completed words count, so a partially written word is never read.
    assign words_avail = wptr[WR_ADDR_W:LR] - rptr;

    assign out_valid   = !rst && (buf_count != 2'd0);
    assign out_data    = obuf0;
    assign pop         = out_valid && out_ready;

    // Words in obuf plus the one in flight must leave room after this cycle's pop.
    assign credit_used = {1'b0, buf_count} + {2'b00, pending};
    assign issue       = !rst && (words_avail != '0) && (credit_used < (pop ? 3'd3 : 3'd2));

    assign mem_rce     = issue;
    assign mem_ra      = rptr[RD_ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            pending   <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            if (accept) begin
                wptr <= wptr + 1'b1;
            end
            if (issue) begin
                rptr <= rptr + 1'b1;
            end
            pending <= issue;
            if (pop) begin
                obuf0 <= obuf1;
            end
            // Arriving read data lands in the first slot free after this cycle's pop.
            if (pending) begin
                if (buf_count == 2'd0 || (buf_count == 2'd1 && pop)) begin
                    obuf0 <= mem_rq;
                end else begin
                    obuf1 <= mem_rq;
                end
            end
            buf_count <= buf_count + {1'b0, pending} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bram_asym_fifo_ctrl.sv
// tb/tb_bram_asym_fifo_ctrl.sv - scoreboard bench for bram_asym_fifo_ctrl (16->32 and 8->32 instances)
module tb_bram_asym_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Instance A: 16 -> 32, 1024 words
    logic        rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [15:0] in_data_a, mem_wd_a;
    logic [31:0] out_data_a, mem_rq_a;
    logic        mem_wce_a, mem_rce_a;
    logic [10:0] mem_wa_a;
    logic [9:0]  mem_ra_a;
    logic [11:0] lane_level_a;

    bram_asym_fifo_ctrl #(.WR_WIDTH(16), .RATIO(2), .RD_ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .mem_wce(mem_wce_a), .mem_wa(mem_wa_a), .mem_wd(mem_wd_a),
        .mem_rce(mem_rce_a), .mem_ra(mem_ra_a), .mem_rq(mem_rq_a),
        .lane_level(lane_level_a)
    );

    // Instance B: 8 -> 32, 16 words (wraps often)
    logic        rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [7:0]  in_data_b, mem_wd_b;
    logic [31:0] out_data_b, mem_rq_b;
    logic        mem_wce_b, mem_rce_b;
    logic [5:0]  mem_wa_b;
    logic [3:0]  mem_ra_b;
    logic [6:0]  lane_level_b;

    bram_asym_fifo_ctrl #(.WR_WIDTH(8), .RATIO(4), .RD_ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .mem_wce(mem_wce_b), .mem_wa(mem_wa_b), .mem_wd(mem_wd_b),
        .mem_rce(mem_rce_b), .mem_ra(mem_ra_b), .mem_rq(mem_rq_b),
        .lane_level(lane_level_b)
    );

    // Asymmetric RAM models: lane-wide write port, word-wide registered read port
    logic [15:0] ram_a [0:2047];
    logic [7:0]  ram_b [0:63];

    always @(posedge clk) begin
        if (mem_wce_a) ram_a[mem_wa_a] <= mem_wd_a;
        if (mem_rce_a) mem_rq_a <= {ram_a[{mem_ra_a, 1'b1}], ram_a[{mem_ra_a, 1'b0}]};
        if (mem_wce_b) ram_b[mem_wa_b] <= mem_wd_b;
        if (mem_rce_b) mem_rq_b <= {ram_b[{mem_ra_b, 2'd3}], ram_b[{mem_ra_b, 2'd2}],
                                    ram_b[{mem_ra_b, 2'd1}], ram_b[{mem_ra_b, 2'd0}]};
    end

    // Scoreboards: words packed little-lane-first from accepted lanes
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] part_a, part_b, held_b;
    int          lane_a = 0, lane_b = 0;
    logic        hold_b = 1'b0;

    always @(negedge clk) begin
        if (rst_a) begin
            qa.delete();
            lane_a = 0;
        end else begin
            if (out_valid_a && out_ready_a) begin
                chk("a_pop_expected", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) chk("a_word", out_data_a, qa.pop_front());
            end
            if (in_valid_a && in_ready_a) begin
                part_a[lane_a*16 +: 16] = in_data_a;
                lane_a++;
                if (lane_a == 2) begin
                    qa.push_back(part_a);
                    lane_a = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b) begin
            qb.delete();
            lane_b = 0;
            hold_b = 1'b0;
        end else begin
            if (hold_b) begin
                chk("b_hold_valid", out_valid_b, 1);
                chk("b_hold_data", out_data_b, held_b);
            end
            hold_b = out_valid_b && !out_ready_b;
            held_b = out_data_b;
            if (out_valid_b && out_ready_b) begin
                chk("b_pop_expected", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) chk("b_word", out_data_b, qb.pop_front());
            end
            if (in_valid_b && in_ready_b) begin
                part_b[lane_b*8 +: 8] = in_data_b;
                lane_b++;
                if (lane_b == 4) begin
                    qb.push_back(part_b);
                    lane_b = 0;
                end
            end
        end
    end

    int nacc, idle, npop, nrce, nb, cyc, c;
    logic [15:0] mid_lanes [0:2];

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        in_valid_a = 1'b1; in_data_a = 16'h1234; out_ready_a = 1'b0;
        in_valid_b = 1'b0; in_data_b = 8'h00; out_ready_b = 1'b0;
        mid_lanes[0] = 16'hDEAD; mid_lanes[1] = 16'hBEEF; mid_lanes[2] = 16'hF00D;

        // Reset held 3 cycles with a lane offered
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready_a, 0);
            chk("rst_wce", mem_wce_a, 0);
            chk("rst_out_valid", out_valid_a, 0);
            chk("rst_rce", mem_rce_a, 0);
            chk("rst_level", lane_level_a, 0);
        end
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0; in_valid_a = 1'b0;
        @(negedge clk);
        chk("post_rst_level", lane_level_a, 0);
        chk("post_rst_in_ready", in_ready_a, 1);
        chk("post_rst_out_valid", out_valid_a, 0);

        // Single word: 0xAAAA then 0x5555
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b1; in_data_a = 16'hAAAA;
        @(negedge clk);
        chk("sw_wce0", mem_wce_a, 1);
        chk("sw_wa0", mem_wa_a, 0);
        chk("sw_wd0", mem_wd_a, 16'hAAAA);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("sw_one_lane_no_rce", mem_rce_a, 0);
        end
        @(posedge clk); #1;
        in_valid_a = 1'b1; in_data_a = 16'h5555;
        @(negedge clk);
        chk("sw_wce1", mem_wce_a, 1);
        chk("sw_wa1", mem_wa_a, 1);
        chk("sw_rce_before_complete", mem_rce_a, 0);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        @(negedge clk);
        chk("sw_rce", mem_rce_a, 1);
        chk("sw_ra", mem_ra_a, 0);
        chk("sw_out_valid_e1", out_valid_a, 0);
        @(negedge clk);
        chk("sw_out_valid_e2", out_valid_a, 0);
        chk("sw_rce_once", mem_rce_a, 0);
        @(negedge clk);
        chk("sw_out_valid", out_valid_a, 1);
        chk("sw_out_data", out_data_a, 32'h5555AAAA);
        @(negedge clk);
        chk("sw_out_valid_after_pop", out_valid_a, 0);

        // Fill with consumer stalled: 1024 words of space plus 2 words pulled into obuf
        out_ready_a = 1'b0;
        nacc = 0; idle = 0;
        for (int k = 0; k < 2300 && idle < 8; k++) begin
            @(posedge clk); #1;
            in_valid_a = 1'b1; in_data_a = 16'(nacc) ^ 16'h3C00;
            @(negedge clk);
            if (in_ready_a) begin
                nacc++;
                idle = 0;
            end else begin
                idle++;
            end
        end
        chk("fill_lanes_accepted", nacc, 2052);
        chk("fill_level", lane_level_a, 2048);
        chk("fill_in_ready", in_ready_a, 0);
        chk("fill_out_valid", out_valid_a, 1);
        chk("fill_no_rce", mem_rce_a, 0);

        @(posedge clk); #1;
        in_valid_a = 1'b0; out_ready_a = 1'b1;
        for (c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (lane_level_a == 0 && !out_valid_a && qa.size() == 0) break;
        end
        chk("fill_drain_done", 64'(c < 3000), 1);

        // Steady state: one word per RATIO cycles, reads never credit-blocked
        npop = 0; nrce = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            in_valid_a = 1'b1; in_data_a = 16'($urandom);
            @(negedge clk);
            if (k >= 100) begin
                if (out_valid_a && out_ready_a) npop++;
                if (mem_rce_a) nrce++;
            end
        end
        chk("steady_pops", npop, 50);
        chk("steady_rce", nrce, 50);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        for (c = 0; c < 50; c++) begin
            @(negedge clk);
            if (lane_level_a == 0 && !out_valid_a && qa.size() == 0) break;
        end
        chk("steady_drain_done", 64'(c < 50), 1);

        // Reset mid-stream with 3 lanes written and 1 word buffered
        out_ready_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid_a = 1'b1; in_data_a = mid_lanes[k];
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_buffered", out_valid_a, 1);
        chk("mid_level", lane_level_a, 1);
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid_a, 0);
        chk("mid_rst_level", lane_level_a, 0);
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b1; in_data_a = 16'h1111;
        @(posedge clk); #1;
        in_data_a = 16'h2222;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        for (c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_rce_a) break;
        end
        chk("mid_rce_seen", 64'(c < 10), 1);
        chk("mid_ra", mem_ra_a, 0);
        for (c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid_a) break;
        end
        chk("mid_out_seen", 64'(c < 10), 1);
        chk("mid_out_data", out_data_a, 32'h22221111);

        // Random streaming on the 8->32 instance with repeated pointer wrap
        nb = 0; cyc = 0;
        while (nb < 5000 && cyc < 40000) begin
            @(posedge clk); #1;
            in_valid_b  = ($urandom_range(0, 3) != 0);
            in_data_b   = 8'(nb * 37 + 5);
            out_ready_b = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid_b && in_ready_b) nb++;
            cyc++;
        end
        chk("stream_lanes", nb, 5000);
        @(posedge clk); #1;
        in_valid_b = 1'b0; out_ready_b = 1'b1;
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (lane_level_b == 0 && !out_valid_b && qb.size() == 0) break;
        end
        chk("stream_drain_done", 64'(c < 200), 1);

        repeat (5) @(negedge clk);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        chk("b_out_idle", out_valid_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
